// File: rtl/pe_pkg.sv
// Shared types and constants for the priority-evaluation line readers.
package pe_pkg;

  localparam int LINE_LEN = 240;

  typedef struct packed {
    logic        transparent;
    logic [1:0]  prio;
    logic [14:0] color;
  } pe_pixel_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} pe_lr_state_t;

endpackage

// File: rtl/pe_line_reader_if.sv
// Pixel stream from the line reader to the priority evaluator (valid/ready).
interface pe_line_reader_if #(
  parameter int PIX_W  = $bits(pe_pkg::pe_pixel_t),
  parameter int ADDR_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_x;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_x, output out_last,
                  input out_ready);
  modport slave  (input out_valid, input out_data, input out_x, input out_last,
                  output out_ready);
endinterface

// File: rtl/pe_counter.sv
// Up-counter with synchronous clear and increment enable.
module pe_counter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= q + 1'b1;
  end

endmodule

// File: rtl/pe_skid_fifo.sv
// Two-entry FIFO with registered head; absorbs the one-cycle buffer read latency.
module pe_skid_fifo #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem1;

  // Head entry is reset so the stream outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= 2'd0;
      head  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) head <= push_data;
        end
        2'b01: begin
          count <= count - 2'd1;
          if (count == 2'd2) head <= mem1;
        end
        2'b11:   head <= (count == 2'd1) ? push_data : mem1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop)))
      mem1 <= push_data;
  end

  assign valid = (count != 2'd0);

endmodule

// File: rtl/pe_line_reader.sv
// Streams one scanline from the selected line-buffer bank to the priority evaluator.
module pe_line_reader #(
  parameter int PIX_W    = $bits(pe_pkg::pe_pixel_t),
  parameter int LINE_LEN = pe_pkg::LINE_LEN,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              line_start,
  input  logic              bank_sel,
  output logic              busy,
  output logic              line_done,
  output logic              overrun,
  output logic              rd_en,
  output logic [ADDR_W:0]   rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  pe_line_reader_if.master  ob
);
  import pe_pkg::*;

  localparam int CNT_W = ADDR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + PIX_W;

  pe_lr_state_t     state, state_nxt;
  logic             bank;
  logic             accept;
  logic             pop;
  logic             inflight_p1;
  logic             done_p1;
  logic [CNT_W-1:0] rd_x;
  logic [CNT_W-1:0] push_x;
  logic             push_last;
  logic [ENT_W-1:0] push_ent;
  logic [ENT_W-1:0] fifo_head;
  logic             fifo_valid;
  logic [1:0]       fifo_count;

  assign pop = ob.out_valid && ob.out_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      bank        <= 1'b0;
      inflight_p1 <= 1'b0;
      done_p1     <= 1'b0;
    end else begin
      state       <= state_nxt;
      inflight_p1 <= rd_en;
      done_p1     <= pop && ob.out_last;
      if (accept) bank <= bank_sel;
    end
  end

  // Reads are throttled so FIFO contents plus the in-flight read never exceed two.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_en     = 1'b0;
    line_done = 1'b0;
    overrun   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        overrun = line_start;
        rd_en   = ({1'b0, fifo_count} + {2'b0, inflight_p1}) < (3'd2 + {2'b0, pop});
        if (rd_en && rd_x == CNT_W'(LINE_LEN - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy    = !done_p1;
        overrun = line_start;
        if (done_p1) begin
          line_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  pe_counter #(.WIDTH(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (accept),
    .inc   (rd_en),
    .q     (rd_x)
  );

  assign rd_addr = {bank, rd_x[ADDR_W-1:0]};

  // p1: read data returns; tag it with its x from the push-side counter.
  pe_counter #(.WIDTH(CNT_W)) u_push_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (accept),
    .inc   (inflight_p1),
    .q     (push_x)
  );

  assign push_last = (push_x == CNT_W'(LINE_LEN - 1));
  assign push_ent  = {push_last, push_x[ADDR_W-1:0], rd_data};

  pe_skid_fifo #(.W(ENT_W)) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (inflight_p1),
    .push_data (push_ent),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // p2: registered FIFO head drives the pixel stream.
  assign ob.out_valid = fifo_valid;
  assign ob.out_data  = fifo_head[PIX_W-1:0];
  assign ob.out_x     = fifo_head[PIX_W +: ADDR_W];
  assign ob.out_last  = fifo_valid && fifo_head[ENT_W-1];

endmodule

// File: tb/tb_pe_line_reader.sv
// Directed + randomized bench for pe_line_reader against a sequence-level line model.
module tb_pe_line_reader;

  localparam int PIX_W  = 18;
  localparam int ADDR_W = 8;
  localparam int LL     = 240;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              line_start = 1'b0;
  logic              bank_sel = 1'b0;
  logic              busy, line_done, overrun, rd_en;
  logic [ADDR_W:0]   rd_addr;
  logic [PIX_W-1:0]  rd_data = '0;

  pe_line_reader_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) oif ();

  pe_line_reader #(.PIX_W(PIX_W), .LINE_LEN(LL), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .line_start (line_start),
    .bank_sel   (bank_sel),
    .busy       (busy),
    .line_done  (line_done),
    .overrun    (overrun),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .ob         (oif)
  );

  always #5 clk = ~clk;

  // Line buffer: returns its address one cycle after rd_en, noise otherwise.
  always @(posedge clk) rd_data <= rd_en ? PIX_W'(rd_addr) : PIX_W'($urandom);

  int total = 0;
  int bad   = 0;

  // Reference model state: what the line should look like from the outside.
  bit m_active, done_due, m_bank, prev_stall, prev_last;
  int reads, xo, cnum, lines, ovs, ready_mode;
  int t_start, t_first_rd, t_last_rd, t_first_out, t_last_out, t_done;
  logic [PIX_W-1:0]  prev_data;
  logic [ADDR_W-1:0] prev_x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_cycle();
    bit xfer, acc;
    logic [PIX_W-1:0] ed;
    cnum++;
    if (!rst_b) begin
      chk("rst_ctl", {busy, line_done, overrun, rd_en, oif.out_valid, oif.out_last}, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_out_data", oif.out_data, 0);
      chk("rst_out_x", oif.out_x, 0);
      m_active = 0; done_due = 0; reads = 0; xo = 0; prev_stall = 0;
      return;
    end
    chk("busy", busy, m_active && !done_due);
    chk("line_done", line_done, done_due);
    chk("overrun", overrun, line_start && m_active);
    if (overrun) ovs++;
    if (rd_en) begin
      chk("rd_en_allowed", m_active && reads < LL, 1);
      chk("rd_addr", rd_addr, {m_bank, reads[ADDR_W-1:0]});
      if (reads == 0) t_first_rd = cnum;
      t_last_rd = cnum;
      reads++;
    end
    xfer = oif.out_valid && oif.out_ready;
    if (prev_stall) begin
      chk("hold_valid", oif.out_valid, 1);
      chk("hold_data", oif.out_data, prev_data);
      chk("hold_x", oif.out_x, prev_x);
      chk("hold_last", oif.out_last, prev_last);
    end
    if (xfer) begin
      ed = '0;
      ed[ADDR_W] = m_bank;
      ed[ADDR_W-1:0] = xo[ADDR_W-1:0];
      chk("no_stale", m_active, 1);
      chk("out_x", oif.out_x, xo);
      chk("out_data", oif.out_data, ed);
      chk("out_last", oif.out_last, xo == LL - 1);
      if (xo == 0) t_first_out = cnum;
      xo++;
    end
    if (rd_en || xfer) chk("occupancy", (reads - xo) >= 0 && (reads - xo) <= 2, 1);
    prev_stall = oif.out_valid && !oif.out_ready;
    prev_data  = oif.out_data;
    prev_x     = oif.out_x;
    prev_last  = oif.out_last;
    acc = line_start && !m_active;
    if (done_due) begin
      done_due = 0; m_active = 0; lines++; t_done = cnum;
    end
    if (xfer && xo == LL) begin
      done_due = 1; t_last_out = cnum;
    end
    if (acc) begin
      m_active = 1; m_bank = bank_sel; reads = 0; xo = 0; t_start = cnum;
    end
  endtask

  task automatic cycle();
    if (ready_mode == 0)      oif.out_ready = 1'b1;
    else if (ready_mode == 1) oif.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input bit b);
    bank_sel = b; line_start = 1'b1;
    cycle();
    line_start = 1'b0; bank_sel = ~b;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int l0;
    l0 = lines;
    for (int i = 0; i < budget && lines == l0; i++) cycle();
    chk(tag, lines - l0, 1);
  endtask

  initial begin
    int o0, l0;
    oif.out_ready = 1'b0;
    ready_mode = 0;
    repeat (3) cycle();
    rst_b = 1'b1;
    cycle();

    // Full-rate line from bank 1 with exact latency checks.
    start_line(1'b1);
    run_to_done("t1_complete", 400);
    chk("lat_first_rd", t_first_rd - t_start, 1);
    chk("lat_last_rd", t_last_rd - t_start, 240);
    chk("lat_first_out", t_first_out - t_start, 3);
    chk("lat_last_out", t_last_out - t_start, 242);
    chk("lat_done", t_done - t_start, 243);
    cycle();

    // Random 50% backpressure.
    ready_mode = 1;
    start_line(1'b0);
    run_to_done("t2_complete", 2000);
    chk("t2_count", xo, LL);
    cycle();

    // Consumer stalled for 20 cycles after line_start.
    ready_mode = 2;
    oif.out_ready = 1'b0;
    start_line(1'b1);
    repeat (20) cycle();
    chk("stall_reads", reads, 2);
    chk("stall_valid", oif.out_valid, 1);
    chk("stall_x", oif.out_x, 0);
    ready_mode = 0;
    run_to_done("t3_complete", 400);
    cycle();

    // line_start in the middle of a line is an overrun and is otherwise ignored.
    o0 = ovs;
    start_line(1'b0);
    repeat (99) cycle();
    start_line(1'b1);
    run_to_done("t4_complete", 400);
    chk("t4_overrun_count", ovs - o0, 1);
    cycle();

    // line_start coincident with line_done, then one cycle later.
    ready_mode = 1;
    start_line(1'b0);
    for (int i = 0; i < 2000 && !done_due; i++) cycle();
    chk("t5_reach_last", done_due, 1);
    o0 = ovs;
    l0 = lines;
    start_line(1'b0);
    chk("t5_overrun", ovs - o0, 1);
    chk("t5_done", lines - l0, 1);
    start_line(1'b1);
    chk("t5_busy_new", busy, 1);
    run_to_done("t5_complete", 2000);
    cycle();

    // Reset in the middle of a line.
    start_line(1'b0);
    repeat (49) cycle();
    l0 = lines;
    rst_b = 1'b0;
    repeat (3) cycle();
    rst_b = 1'b1;
    cycle();
    chk("t6_no_done", lines - l0, 0);
    chk("t6_no_stale", oif.out_valid, 0);
    start_line(1'b1);
    run_to_done("t6_complete", 2000);
    chk("t6_count", xo, LL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
